// File: rtl/sar_pkg.sv
// Shared types and widths for the sar_search8 successive-approximation controller.
package sar_pkg;

  localparam int unsigned SAR_STEPS_W = 4;
  localparam int unsigned SAR_CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sar_state_t;

endpackage

// File: rtl/sar_settle_cnt.sv
// Loadable down-counter; expired rises once the loaded count has been consumed.
module sar_settle_cnt
  import sar_pkg::*;
#(
  parameter int unsigned W = SAR_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  // expired is registered: a load of 0 expires on the first counted cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt_q   <= load_val;
      expired <= (load_val == '0);
    end else if (en && !expired) begin
      cnt_q   <= cnt_q - W'(1);
      expired <= (cnt_q == W'(1));
    end
  end

endmodule

// File: rtl/sar_search8.sv
// Successive-approximation search over an external magnitude comparator, MSB first.
// Optional build macro SAR_EARLY_EXIT_EN: stop as soon as the comparator reports equal.
module sar_search8
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   GREATER,
  input  logic                   LESSER,
  output logic [WIDTH-1:0]       probe,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic [SAR_STEPS_W-1:0] steps,
  output logic                   err
);

  localparam int unsigned IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [WIDTH-1:0] PROBE_INIT = WIDTH'(1) << (WIDTH - 1);
  localparam sar_state_t PROBE_NEXT = (SETTLE > 0) ? sar_pkg::SETTLE : SAMPLE;

  sar_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]       probe_d, result_d;
  logic [SAR_STEPS_W-1:0] steps_d;
  logic                   err_d, busy_d, done_d;
  logic                   settle_load_c, settle_en_c, settle_expired;
  logic                   eq_exit_c;

`ifdef SAR_EARLY_EXIT_EN
  assign eq_exit_c = !GREATER && !LESSER;
`else
  assign eq_exit_c = 1'b0;
`endif

  sar_settle_cnt #(.W(SAR_CNT_W)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load_c),
    .en       (settle_en_c),
    .load_val (SAR_CNT_W'(SETTLE_LOAD)),
    .expired  (settle_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      probe   <= '0;
      result  <= '0;
      steps   <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      probe   <= probe_d;
      result  <= result_d;
      steps   <= steps_d;
      err     <= err_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    probe_d  = probe;
    result_d = result;
    steps_d  = steps;
    err_d    = err;

    case (state_q)
      IDLE: begin
        if (start) begin
          probe_d = PROBE_INIT;
          idx_d   = IDX_W'(WIDTH - 1);
          steps_d = '0;
          err_d   = 1'b0;
          state_d = PROBE_NEXT;
        end
      end
      sar_pkg::SETTLE: begin
        if (settle_expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        steps_d = steps + SAR_STEPS_W'(1);
        if (GREATER && LESSER) err_d = 1'b1;
        // contradictory flags fall through as "not lesser", so the bit stays set
        if (LESSER && !GREATER) probe_d[idx_q] = 1'b0;
        // bits below idx are still clear, so the probe already is the answer on equal
        if (eq_exit_c || (idx_q == '0)) begin
          result_d = probe_d;
          state_d  = DONE;
        end else begin
          probe_d[IDX_W'(idx_q - IDX_W'(1))] = 1'b1;
          idx_d   = IDX_W'(idx_q - IDX_W'(1));
          state_d = PROBE_NEXT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d        = (state_d == sar_pkg::SETTLE) || (state_d == SAMPLE);
    done_d        = (state_d == DONE);
    settle_load_c = (state_d == sar_pkg::SETTLE) && (state_q != sar_pkg::SETTLE);
    settle_en_c   = (state_q == sar_pkg::SETTLE);
  end

endmodule

// File: tb/tb_sar_search8.sv
// Directed bench for sar_search8: two instances (SETTLE=0 and SETTLE=2) fed by a modelled comparator.
`timescale 1ns/1ps
module tb_sar_search8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start2, frc0, frc2;
  logic [7:0] tgt0, tgt2;
  logic       gt0, lt0, gt2, lt2;
  logic [7:0] probe0, probe2, result0, result2;
  logic [3:0] steps0, steps2;
  logic       busy0, busy2, done0, done2, err0, err2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] plog [0:511];
  logic       elog [0:511];
  logic [7:0] r_res;
  logic [3:0] r_steps;
  logic       r_err, r_busy;
  int         lat;

  always #5 clk = ~clk;

  // comparator: target on a, probe on b; frc drives both flags high
  assign gt0 = frc0 | (tgt0 > probe0);
  assign lt0 = frc0 | (tgt0 < probe0);
  assign gt2 = frc2 | (tgt2 > probe2);
  assign lt2 = frc2 | (tgt2 < probe2);

  sar_search8 #(.WIDTH(8), .SETTLE(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start0), .GREATER(gt0), .LESSER(lt0),
    .probe(probe0), .busy(busy0), .done(done0), .result(result0),
    .steps(steps0), .err(err0)
  );

  sar_search8 #(.WIDTH(8), .SETTLE(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start2), .GREATER(gt2), .LESSER(lt2),
    .probe(probe2), .busy(busy2), .done(done2), .result(result2),
    .steps(steps2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start2 = v; else start0 = v;
  endtask

  task automatic set_frc(input bit sel, input logic v);
    if (sel) frc2 = v; else frc0 = v;
  endtask

  // one search; logs probe/err per cycle, snapshots outputs at done, optionally pokes start/force/rst
  task automatic run(input bit sel, input logic [7:0] tgt, input int fs, input int rst_at,
                     input int ign_at, input bit dn_start, output int lt);
    int n;
    if (sel) tgt2 = tgt; else tgt0 = tgt;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    lt = -1;
    n  = 1;
    while (n < 400) begin
      plog[n] = sel ? probe2 : probe0;
      elog[n] = sel ? err2 : err0;
      if (rst_at > 0 && n == rst_at + 1) break;
      if (sel ? done2 : done0) begin
        lt = n;
        break;
      end
      set_frc(sel, n == fs);
      if (n == ign_at) set_start(sel, 1'b1);
      if (n == rst_at) rst = 1'b1;
      tick();
      set_frc(sel, 1'b0);
      set_start(sel, 1'b0);
      rst = 1'b0;
      n++;
    end
    if (lt > 0) begin
      r_res   = sel ? result2 : result0;
      r_steps = sel ? steps2 : steps0;
      r_err   = sel ? err2 : err0;
      r_busy  = sel ? busy2 : busy0;
      if (dn_start) set_start(sel, 1'b1);
      tick();
      set_start(sel, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] seq33 [0:7];
    logic [7:0] e;
    seq33 = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h34, 8'h32, 8'h33};
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; frc0 = 1'b0; frc2 = 1'b0;
    tgt0 = 8'h00; tgt2 = 8'h00;
    tick(); tick();
    check("rst_probe",  32'(probe0),  32'h0);
    check("rst_result", 32'(result0), 32'h0);
    check("rst_steps",  32'(steps0),  32'h0);
    check("rst_flags",  32'({busy0, done0, err0, busy2, done2, err2}), 32'h0);
    rst = 1'b0;
    tick();

    // 0x5A, with a start ignored mid-search and another ignored in the DONE cycle
    run(1'b0, 8'h5A, 0, 0, 3, 1'b1, lat);
    check("5a_probe_c1", 32'(plog[1]), 32'h80);
    check("5a_ign_start_probe", 32'(plog[4]), 32'h50);
    check("5a_result", 32'(r_res), 32'h5A);
    check("5a_err", 32'(r_err), 32'h0);
    check("5a_busy_at_done", 32'(r_busy), 32'h0);
`ifdef SAR_EARLY_EXIT_EN
    check("5a_latency", 32'(lat), 32'd8);
    check("5a_steps", 32'(r_steps), 32'd7);
`else
    check("5a_latency", 32'(lat), 32'd9);
    check("5a_steps", 32'(r_steps), 32'd8);
`endif
    check("done_start_ignored", 32'({busy0, done0}), 32'h0);

    // 0x00: every bit cleared, probe walks 80..01
    run(1'b0, 8'h00, 0, 0, 0, 1'b0, lat);
    check("00_latency", 32'(lat), 32'd9);
    check("00_result", 32'(r_res), 32'h00);
    check("00_steps", 32'(r_steps), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      e = 8'h80 >> (k - 1);
      check($sformatf("00_probe_c%0d", k), 32'(plog[k]), 32'(e));
    end

    // 0xFF: every bit kept
    run(1'b0, 8'hFF, 0, 0, 0, 1'b0, lat);
    check("ff_latency", 32'(lat), 32'd9);
    check("ff_result", 32'(r_res), 32'hFF);
    check("ff_steps", 32'(r_steps), 32'd8);

    // 0x80: equal at the very first sample
    run(1'b0, 8'h80, 0, 0, 0, 1'b0, lat);
    check("80_result", 32'(r_res), 32'h80);
`ifdef SAR_EARLY_EXIT_EN
    check("80_latency", 32'(lat), 32'd2);
    check("80_steps", 32'(r_steps), 32'd1);
`else
    check("80_latency", 32'(lat), 32'd9);
    check("80_steps", 32'(r_steps), 32'd8);
`endif

    // SETTLE=2, 0x33: 3 cycles per bit, probe steady within each window
    run(1'b1, 8'h33, 0, 0, 0, 1'b0, lat);
    check("33_latency", 32'(lat), 32'd25);
    check("33_result", 32'(r_res), 32'h33);
    check("33_steps", 32'(r_steps), 32'd8);
    for (int n = 1; n <= 24; n++)
      check($sformatf("33_probe_c%0d", n), 32'(plog[n]), 32'(seq33[(n - 1) / 3]));

    // both flags forced at step 3: bit kept, err sticky through done
    run(1'b0, 8'h5A, 3, 0, 0, 1'b0, lat);
    check("err_before", 32'(elog[3]), 32'h0);
    check("err_after", 32'(elog[4]), 32'h1);
    check("err_latency", 32'(lat), 32'd9);
    check("err_at_done", 32'(r_err), 32'h1);
    check("err_result", 32'(r_res), 32'h60);
    run(1'b0, 8'h5A, 0, 0, 0, 1'b0, lat);
    check("err_cleared_on_start", 32'(elog[1]), 32'h0);
    check("err_rerun_result", 32'(r_res), 32'h5A);

    // reset during step 4
    run(1'b0, 8'h5A, 0, 4, 0, 1'b0, lat);
    check("midrst_probe", 32'(probe0), 32'h0);
    check("midrst_result", 32'(result0), 32'h0);
    check("midrst_steps", 32'(steps0), 32'h0);
    check("midrst_flags", 32'({busy0, done0, err0}), 32'h0);
    tick();
    run(1'b0, 8'hC3, 0, 0, 0, 1'b0, lat);
    check("post_rst_result", 32'(r_res), 32'hC3);
    check("post_rst_latency", 32'(lat), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
